// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: N-way operand select feeding a registered
// 2-entry skid buffer with valid/ready handshakes and flush.
module pipe_sel_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N*WIDTH-1:0]         din,
    input  logic [$clog2(N)-1:0]       sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_err,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int SEL_W = $clog2(N);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_err   = main_err;

    // select the offered word; any index past N yields zero with err set
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                cap_data = din[i*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // entry-count state machine with main/skid storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= cap_data;
                        main_err  <= cap_err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_data <= cap_data;
                        skid_err  <= cap_err;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (accept && pop) begin
                        main_data <= cap_data;
                        main_err  <= cap_err;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_data <= skid_data;
                        main_err  <= skid_err;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
